// File: rtl/alu_mc_if.sv
// Handshake and operand/result bundle for alu_mc.
// The master drives the request and the consumer ready; the slave is the ALU.
interface alu_mc_if #(
    parameter int W   = 8,
    parameter int Ops = 4
);
    logic           InValid;
    logic           InReady;
    logic [W-1:0]   InputA;
    logic [W-1:0]   InputB;
    logic [Ops-1:0] OP;
    logic           OutValid;
    logic           OutReady;
    logic [W-1:0]   Out;
    logic [W-1:0]   OutHi;
    logic           Jump;
    logic           Zero;
    logic           Parity;
    logic           Illegal;
    logic           DivZero;

    modport master (
        output InValid, InputA, InputB, OP, OutReady,
        input  InReady, OutValid, Out, OutHi, Jump, Zero, Parity, Illegal, DivZero
    );

    modport slave (
        input  InValid, InputA, InputB, OP, OutReady,
        output InReady, OutValid, Out, OutHi, Jump, Zero, Parity, Illegal, DivZero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish from IDLE, MUL/DIVU iterate one bit
// per cycle in ITER. All results and flags are registered behind a valid/ready pair.
module alu_mc #(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input logic    Clk,
    input logic    Reset,
    alu_mc_if.slave bus
);
    localparam int            CW      = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);
    localparam logic [W-1:0]  W_VAL   = W'(W);

    localparam logic [Ops-1:0] OP_ADD  = Ops'(0);
    localparam logic [Ops-1:0] OP_XOR  = Ops'(1);
    localparam logic [Ops-1:0] OP_ORR  = Ops'(2);
    localparam logic [Ops-1:0] OP_BGT  = Ops'(3);
    localparam logic [Ops-1:0] OP_BNE  = Ops'(4);
    localparam logic [Ops-1:0] OP_SLL  = Ops'(5);
    localparam logic [Ops-1:0] OP_SRL  = Ops'(6);
    localparam logic [Ops-1:0] OP_XXR  = Ops'(7);
    localparam logic [Ops-1:0] OP_SUB  = Ops'(8);
    localparam logic [Ops-1:0] OP_AND  = Ops'(9);
    localparam logic [Ops-1:0] OP_EQL  = Ops'(10);
    localparam logic [Ops-1:0] OP_MUL  = Ops'(11);
    localparam logic [Ops-1:0] OP_DIVU = Ops'(12);

    typedef enum logic {IDLE, ITER} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc, mq, opnd;
    logic          is_div, dz_pend;

    logic [W-1:0]  out_r, outhi_r;
    logic          out_valid, jump_r, zero_r, parity_r, illegal_r, divzero_r;

    logic          in_ready, accept, is_iter_op;
    logic [W-1:0]  sc_out;
    logic          sc_jump, sc_illegal;
    logic [W:0]    sum, shifted, diff;
    logic          ge;
    logic [W-1:0]  nxt_acc, nxt_mq;

    assign in_ready   = (state == IDLE) && (!out_valid || bus.OutReady);
    assign accept     = bus.InValid && in_ready;
    assign is_iter_op = (bus.OP == OP_MUL) || (bus.OP == OP_DIVU);

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        sc_out     = '0;
        sc_jump    = 1'b0;
        sc_illegal = 1'b0;
        case (bus.OP)
            OP_ADD:  sc_out = bus.InputA + bus.InputB;
            OP_XOR:  sc_out = bus.InputA ^ bus.InputB;
            OP_ORR:  sc_out = bus.InputA | bus.InputB;
            OP_SUB:  sc_out = bus.InputA - bus.InputB;
            OP_AND:  sc_out = bus.InputA & bus.InputB;
            OP_XXR:  sc_out = W'(^{bus.InputA, bus.InputB});
            OP_SLL:  sc_out = (bus.InputB >= W_VAL) ? '0 : bus.InputA << bus.InputB;
            OP_SRL:  sc_out = (bus.InputB >= W_VAL) ? '0 : bus.InputA >> bus.InputB;
            OP_BGT: begin
                sc_jump = bus.InputA > bus.InputB;
                sc_out  = W'(sc_jump);
            end
            OP_BNE: begin
                sc_jump = bus.InputA != bus.InputB;
                sc_out  = W'(sc_jump);
            end
            OP_EQL: begin
                sc_jump = bus.InputA == bus.InputB;
                sc_out  = W'(sc_jump);
            end
            OP_MUL, OP_DIVU: sc_out = '0;
            default: sc_illegal = 1'b1;
        endcase
    end

    // One iteration step: shift-add multiply (acc:mq shifts right) or
    // restoring divide (acc:mq shifts left, quotient bits enter mq[0]).
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, (mq[0] ? opnd : '0)};
        shifted = {acc, mq[W-1]};
        ge      = shifted >= {1'b0, opnd};
        diff    = shifted - {1'b0, opnd};
        if (is_div) begin
            nxt_acc = ge ? diff[W-1:0] : shifted[W-1:0];
            nxt_mq  = {mq[W-2:0], ge};
        end else begin
            nxt_acc = sum[W:1];
            nxt_mq  = {sum[0], mq[W-1:1]};
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            mq        <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            dz_pend   <= 1'b0;
            out_r     <= '0;
            outhi_r   <= '0;
            out_valid <= 1'b0;
            jump_r    <= 1'b0;
            zero_r    <= 1'b0;
            parity_r  <= 1'b0;
            illegal_r <= 1'b0;
            divzero_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_iter_op) begin
                        state     <= ITER;
                        cnt       <= CNT_TOP;
                        acc       <= '0;
                        mq        <= bus.InputA;
                        opnd      <= bus.InputB;
                        is_div    <= (bus.OP == OP_DIVU);
                        dz_pend   <= (bus.OP == OP_DIVU) && (bus.InputB == '0);
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_r     <= sc_out;
                        outhi_r   <= '0;
                        jump_r    <= sc_jump;
                        zero_r    <= ~|sc_out;
                        parity_r  <= ^sc_out;
                        illegal_r <= sc_illegal;
                        divzero_r <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (out_valid && bus.OutReady) begin
                        out_valid <= 1'b0;
                    end
                end
                ITER: begin
                    acc <= nxt_acc;
                    mq  <= nxt_mq;
                    if (cnt == '0) begin
                        state     <= IDLE;
                        out_r     <= nxt_mq;
                        outhi_r   <= nxt_acc;
                        jump_r    <= 1'b0;
                        zero_r    <= ~|nxt_mq;
                        parity_r  <= ^nxt_mq;
                        illegal_r <= 1'b0;
                        divzero_r <= dz_pend;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.OutValid = out_valid;
    assign bus.Out      = out_r;
    assign bus.OutHi    = outhi_r;
    assign bus.Jump     = jump_r;
    assign bus.Zero     = zero_r;
    assign bus.Parity   = parity_r;
    assign bus.Illegal  = illegal_r;
    assign bus.DivZero  = divzero_r;
endmodule
